// File: rtl/fifo_buffer_if.sv
// Handshake/data bundle for fifo_buffer: enable, push/pop requests, write data, head word and status.
// Carries overflow/underflow only when FIFO_BUFFER_ERROR_FLAGS_EN is defined.
interface fifo_buffer_if #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
);
    localparam int unsigned CountW = $clog2(Depth + 1);

    logic              ce;
    logic              push;
    logic              pop;
    logic [Width-1:0]  D;
    logic [Width-1:0]  Q;
    logic              full;
    logic              empty;
    logic [CountW-1:0] count;

`ifdef FIFO_BUFFER_ERROR_FLAGS_EN
    logic              overflow;
    logic              underflow;

    modport master (
        output ce, push, pop, D,
        input  Q, full, empty, count, overflow, underflow
    );

    modport slave (
        input  ce, push, pop, D,
        output Q, full, empty, count, overflow, underflow
    );
`else
    modport master (
        output ce, push, pop, D,
        input  Q, full, empty, count
    );

    modport slave (
        input  ce, push, pop, D,
        output Q, full, empty, count
    );
`endif
endinterface

// File: rtl/fifo_buffer.sv
// Depth-entry synchronous first-word-fall-through FIFO with global clock enable; Q shows Init when empty.
// Optional sticky overflow/underflow flags are built when FIFO_BUFFER_ERROR_FLAGS_EN is defined.
module fifo_buffer #(
    parameter int unsigned      Width = 8,
    parameter int unsigned      Depth = 4,
    parameter logic [Width-1:0] Init  = '0
) (
    input logic          clk,
    input logic          rst,
    fifo_buffer_if.slave bus
);
    localparam int unsigned       PtrW       = $clog2(Depth);
    localparam int unsigned       CountW     = $clog2(Depth + 1);
    localparam logic [PtrW-1:0]   LastPtr    = PtrW'(Depth - 1);
    localparam logic [CountW-1:0] DepthCount = CountW'(Depth);

    logic [Width-1:0]  mem [Depth];
    logic [PtrW-1:0]   wptr;
    logic [PtrW-1:0]   rptr;
    logic [CountW-1:0] cnt;

    logic is_empty;
    logic is_full;
    logic pop_ok;
    logic push_ok;

    // Explicit wrap so non-power-of-two depths never address past the last entry.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        is_empty = 1'b0;
        is_full  = 1'b0;
        pop_ok   = 1'b0;
        push_ok  = 1'b0;
        is_empty = (cnt == '0);
        is_full  = (cnt == DepthCount);
        pop_ok   = bus.ce & bus.pop & ~is_empty;
        push_ok  = bus.ce & bus.push & (~is_full | pop_ok);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) wptr <= ptr_inc(wptr);
            if (pop_ok)  rptr <= ptr_inc(rptr);
            unique case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CountW'(1);
                2'b01:   cnt <= cnt - CountW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage has no reset; empty masks it from Q, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= bus.D;
    end

    assign bus.Q     = is_empty ? Init : mem[rptr];
    assign bus.full  = is_full;
    assign bus.empty = is_empty;
    assign bus.count = cnt;

`ifdef FIFO_BUFFER_ERROR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.ce) begin
            if (bus.push && !push_ok) overflow_q  <= 1'b1;
            if (bus.pop && is_empty)  underflow_q <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule
